// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Front-end fetch stage. Owns the program counter, issues
//            word-aligned requests to instruction memory, buffers returned
//            words in an in-order prefetch FIFO and hands them to decode
//            over a valid/ready handshake tagged with their PC. A redirect
//            flushes the FIFO and drops responses still in flight.
// Ports    : clk_i, rst_ni            clock, async active-low reset
//            imem_req_o/addr_o/gnt_i  request channel to instruction memory
//            imem_rvalid_i/rdata_i    in-order response channel
//            instr_valid_o/ready_i    handshake to decode
//            instr_o, instr_pc_o      FIFO head (zero when empty)
//            redirect_i, redirect_pc_i  flush and restart fetch
// Config   : FETCH_BYPASS_EN - when defined, a response arriving while the
//            FIFO is empty is presented to decode in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_L = (c_CNT_W + 1)'(DEPTH);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        rsp_pc_q, rsp_pc_d;
    logic [31:0]        fifo_instr_q [DEPTH];
    logic [31:0]        fifo_pc_q    [DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_CNT_W-1:0] outst_q, outst_d;
    logic [c_CNT_W-1:0] discard_q, discard_d;

    logic [c_CNT_W:0]   w_level;
    logic               w_req;
    logic               w_issue;
    logic               w_drop;
    logic               w_accept;
    logic               w_nonempty;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push;
    logic [31:0]        w_redirect_pc;
    logic               w_unused_pc_lsb;

    // Buffered plus in-flight words never exceed DEPTH, so every response
    // is guaranteed a free FIFO slot when it returns.
    assign w_level    = {1'b0, count_q} + {1'b0, outst_q};
    // Gated by reset so no request leaks out while rst_ni is held low.
    assign w_req      = rst_ni & ~redirect_i & (w_level < c_DEPTH_L);
    assign w_issue    = w_req & imem_gnt_i;
    // Stale responses (older than the last redirect) and any response that
    // lands in a redirect cycle are dropped.
    assign w_drop     = imem_rvalid_i & (redirect_i | (discard_q != '0));
    assign w_accept   = imem_rvalid_i & ~w_drop;
    assign w_nonempty = (count_q != '0);
    assign w_pop      = w_nonempty & ~redirect_i & instr_ready_i;

    assign w_redirect_pc   = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

    assign imem_req_o  = w_req;
    assign imem_addr_o = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    // Empty FIFO: the arriving word goes straight to decode this cycle.
    assign w_bypass      = ~w_nonempty & w_accept;
    assign instr_valid_o = (w_nonempty & ~redirect_i) | w_bypass;
    assign instr_o       = w_bypass   ? imem_rdata_i :
                           w_nonempty ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = w_bypass   ? rsp_pc_q :
                           w_nonempty ? fifo_pc_q[rd_ptr_q] : 32'h0;
`else
    assign w_bypass      = 1'b0;
    assign instr_valid_o = w_nonempty & ~redirect_i;
    assign instr_o       = w_nonempty ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = w_nonempty ? fifo_pc_q[rd_ptr_q] : 32'h0;
`endif

    // A bypassed word that decode takes immediately never enters the FIFO.
    assign w_push = w_accept & ~(w_bypass & instr_ready_i);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + c_CNT_W'(w_issue) - c_CNT_W'(imem_rvalid_i);

        if (redirect_i) begin
            fetch_pc_d = w_redirect_pc;
            rsp_pc_d   = w_redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this edge is stale.
            discard_d  = outst_q - c_CNT_W'(imem_rvalid_i);
        end else begin
            if (w_issue)  fetch_pc_d = fetch_pc_q + 32'd4;
            if (w_accept) rsp_pc_d   = rsp_pc_q + 32'd4;
            if (w_push)   wr_ptr_d   = wr_ptr_q + 1'b1;
            if (w_pop)    rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Storage needs no reset: the output mux hides it while count is zero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. A behavioural
//            instruction memory grants every request and answers in order
//            after a configurable latency with data derived from the address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req, imem_gnt = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        bit          ready;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    pend_t q[$];
    int    lat = 1;
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    vec_t  tbl [22];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    function automatic vec_t mk(input bit rdy, input bit rq, input logic [31:0] ad,
                                input bit vl, input logic [31:0] pc);
        vec_t v;
        v.ready = rdy; v.req = rq; v.addr = ad; v.valid = vl; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        else
            n_pass++;
    endtask

    // One clock cycle: drive decode/redirect inputs, let memory answer and
    // grant, then leave outputs settled for sampling well before the edge.
    task automatic tick(input bit rdy, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        if (q.size() > 0 && q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q[0].addr);
            void'(q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        imem_gnt = imem_req;
        if (imem_req) q.push_back('{addr: imem_addr, due: cyc + lat});
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int l);
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        q.delete();
        lat = l;
        #1;
        chk("rst_req_async",   imem_req,    0);
        chk("rst_valid_async", instr_valid, 0);
        chk("rst_instr_async", instr,       0);
        chk("rst_pc_async",    instr_pc,    0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_held", imem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] epc);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (instr_valid) seen = 1'b1;
        end
        chk({nm, "_seen"}, 32'(seen), 1);
        if (seen) begin
            chk({nm, "_pc"},    instr_pc, epc);
            chk({nm, "_instr"}, instr,    mem_word(epc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        // Zero-wait startup, then a 10-cycle decode stall and drain.
        tbl[0]  = mk(1, 1, 32'h100, 0, 32'h0);
        tbl[1]  = mk(1, 1, 32'h104, 0, 32'h0);
        tbl[2]  = mk(1, 1, 32'h108, 1, 32'h100);
        tbl[3]  = mk(1, 1, 32'h10C, 1, 32'h104);
        tbl[4]  = mk(1, 1, 32'h110, 1, 32'h108);
        tbl[5]  = mk(1, 1, 32'h114, 1, 32'h10C);
        tbl[6]  = mk(0, 1, 32'h118, 1, 32'h110);
        tbl[7]  = mk(0, 1, 32'h11C, 1, 32'h110);
        tbl[8]  = mk(0, 0, 32'h120, 1, 32'h110);
        for (int i = 9; i <= 15; i++) tbl[i] = mk(0, 0, 32'h120, 1, 32'h110);
        tbl[16] = mk(1, 0, 32'h120, 1, 32'h110);
        tbl[17] = mk(1, 1, 32'h120, 1, 32'h114);
        tbl[18] = mk(1, 1, 32'h124, 1, 32'h118);
        tbl[19] = mk(1, 1, 32'h128, 1, 32'h11C);
        tbl[20] = mk(1, 1, 32'h12C, 1, 32'h120);
        tbl[21] = mk(1, 1, 32'h130, 1, 32'h124);

        #3;
        do_reset(1);

`ifdef FETCH_BYPASS_EN
        // Empty FIFO: response is visible to decode in its arrival cycle.
        tick(1'b1, 1'b0, 32'h0);
        chk("byp_k0_valid", instr_valid, 0);
        tick(1'b1, 1'b0, 32'h0);
        chk("byp_k1_valid", instr_valid, 1);
        chk("byp_k1_pc",    instr_pc,    32'h100);
        chk("byp_k1_instr", instr,       mem_word(32'h100));
        tick(1'b1, 1'b0, 32'h0);
        chk("byp_k2_valid", instr_valid, 1);
        chk("byp_k2_pc",    instr_pc,    32'h104);
`else
        for (int k = 0; k < 22; k++) begin
            tick(tbl[k].ready, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", k),   imem_req,    32'(tbl[k].req));
            chk($sformatf("tbl%0d_addr", k),  imem_addr,   tbl[k].addr);
            chk($sformatf("tbl%0d_valid", k), instr_valid, 32'(tbl[k].valid));
            if (tbl[k].valid) begin
                chk($sformatf("tbl%0d_pc", k),    instr_pc, tbl[k].pc);
                chk($sformatf("tbl%0d_instr", k), instr,    mem_word(tbl[k].pc));
            end
        end
`endif

        // 3-cycle memory, two requests in flight when the redirect lands.
        do_reset(3);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("lat3_k1_addr", imem_addr, 32'h104);
        tick(1'b1, 1'b1, 32'h0000_2003);
        chk("lat3_redir_req",   imem_req,    0);
        chk("lat3_redir_valid", instr_valid, 0);
        tick(1'b1, 1'b0, 32'h0);
        chk("lat3_new_req",  imem_req,  1);
        chk("lat3_new_addr", imem_addr, 32'h2000);
        wait_valid("lat3_first", 32'h2000);
        tick(1'b1, 1'b0, 32'h0);
        chk("lat3_second_valid", instr_valid, 1);
        chk("lat3_second_pc",    instr_pc,    32'h2004);

        // Redirect coinciding with a handshake and an arriving response.
        do_reset(1);
        repeat (4) tick(1'b1, 1'b0, 32'h0);
        chk("same_pre_valid", instr_valid, 1);
        tick(1'b1, 1'b1, 32'h0000_0300);
        chk("same_rvalid_present", imem_rvalid, 1);
        chk("same_valid", instr_valid, 0);
        chk("same_req",   imem_req,    0);
        tick(1'b1, 1'b0, 32'h0);
        chk("same_next_valid", instr_valid, 0);
        chk("same_next_addr",  imem_addr,   32'h300);
        wait_valid("same_target", 32'h300);

        // Fetch PC wraps from the last word to address zero.
        tick(1'b1, 1'b1, 32'hFFFF_FFFE);
        tick(1'b1, 1'b0, 32'h0);
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req_top",  imem_req,  1);
        tick(1'b1, 1'b0, 32'h0);
        chk("wrap_addr_zero", imem_addr, 32'h0);
        wait_valid("wrap_top", 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'h0);
        chk("wrap_zero_valid", instr_valid, 1);
        chk("wrap_zero_pc",    instr_pc,    32'h0);

        // Reset asserted mid-stream forgets everything in flight.
        tick(1'b0, 1'b0, 32'h0);
        #1;
        do_reset(1);
        tick(1'b1, 1'b0, 32'h0);
        chk("rst2_addr", imem_addr, 32'h100);
        wait_valid("rst2_first", 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
